// File: rtl/hpdcache_l15_req_arbiter_rt.sv
`default_nettype none
// ============================================================================
// Module   : hpdcache_l15_req_arbiter_rt
// Purpose  : Request-side scheduler for the L1.5 memory interface. Arbitrates
//            N requester ports round-robin onto one memory request channel,
//            allocates a free transaction ID per request and keeps a routing
//            table ID -> requester port used to steer memory responses.
// Ports    :
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_valid_i[N]     per-port request valid
//   req_ready_o[N]     per-port request accepted (one-hot or zero)
//   mem_req_valid_o    request to memory valid
//   mem_req_ready_i    memory accepts request
//   mem_req_sel_o      granted port index (external payload mux select)
//   mem_req_id_o       allocated transaction ID for the granted request
//   mem_resp_valid_i   memory response valid (observed only)
//   mem_resp_ready_i   response accepted by the demux
//   mem_resp_id_i      response transaction ID
//   mem_resp_last_i    last beat of the response
//   mem_resp_sel_o     routing-table port for mem_resp_id_i
//   outstanding_o      number of allocated table entries
//   rt_err_o           pulse: response accepted for an unallocated ID
// Revision : 1.0 - initial release
// ============================================================================
module hpdcache_l15_req_arbiter_rt #(
    parameter int N      = 4,
    parameter int ID_W   = 3,
    parameter int PORT_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      req_valid_i,
    output logic [N-1:0]      req_ready_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [PORT_W-1:0] mem_req_sel_o,
    output logic [ID_W-1:0]   mem_req_id_o,
    input  logic              mem_resp_valid_i,
    input  logic              mem_resp_ready_i,
    input  logic [ID_W-1:0]   mem_resp_id_i,
    input  logic              mem_resp_last_i,
    output logic [PORT_W-1:0] mem_resp_sel_o,
    output logic [ID_W:0]     outstanding_o,
    output logic              rt_err_o
);

    localparam int RT_DEPTH = 2 ** ID_W;

    // Routing table and arbitration state
    logic [RT_DEPTH-1:0] r_rt_valid;
    logic [PORT_W-1:0]   r_rt_port [RT_DEPTH];
    logic [PORT_W-1:0]   r_ptr;
    logic                r_lock;
    logic [PORT_W-1:0]   r_lock_sel;
    logic [ID_W-1:0]     r_lock_id;
    logic [ID_W:0]       r_outstanding;
    logic                r_rt_err;

    logic                w_free_exists;
    logic [ID_W-1:0]     w_free_id;
    logic [PORT_W-1:0]   w_rr_sel;
    logic                w_rr_found;
    logic                w_mem_req_valid;
    logic                w_hs;
    logic [PORT_W-1:0]   w_sel;
    logic [ID_W-1:0]     w_id;
    logic [PORT_W-1:0]   w_ptr_nxt;
    logic                w_resp_hit;
    logic                w_resp_acc;
    logic                w_free;
    logic                w_err;
    logic [RT_DEPTH-1:0] w_rt_valid_nxt;

    // Lowest-numbered invalid entry, sampled from the pre-update table so an
    // entry freed this cycle only becomes allocatable next cycle.
    always_comb begin
        w_free_exists = ~&r_rt_valid;
        w_free_id     = '0;
        for (int i = RT_DEPTH - 1; i >= 0; i--) begin
            if (!r_rt_valid[ID_W'(i)]) begin
                w_free_id = ID_W'(i);
            end
        end
    end

    // Round-robin search starting at r_ptr, wrapping at N
    always_comb begin
        int                idx;
        logic [PORT_W-1:0] w_idx;
        w_rr_sel   = r_ptr;
        w_rr_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            w_idx = PORT_W'(idx);
            if (!w_rr_found && req_valid_i[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_sel   = w_idx;
            end
        end
    end

    // Valid is independent of mem_req_ready_i; gated off while in reset since
    // the combinational term would otherwise see raw request valids.
    assign w_mem_req_valid = rst_ni & (r_lock | ((|req_valid_i) & w_free_exists));
    assign w_hs            = w_mem_req_valid & mem_req_ready_i;

    // Once offered and stalled, grant and ID are frozen in the lock registers
    assign w_sel     = r_lock ? r_lock_sel : w_rr_sel;
    assign w_id      = r_lock ? r_lock_id  : w_free_id;
    assign w_ptr_nxt = (w_sel == PORT_W'(N - 1)) ? '0 : w_sel + 1'b1;

    always_comb begin
        req_ready_o = '0;
        if (w_hs) begin
            req_ready_o[w_sel] = 1'b1;
        end
    end

    // Response lookup
    assign w_resp_hit = r_rt_valid[mem_resp_id_i];
    assign w_resp_acc = mem_resp_valid_i & mem_resp_ready_i;
    assign w_free     = w_resp_acc & mem_resp_last_i & w_resp_hit;
    assign w_err      = w_resp_acc & ~w_resp_hit;

    // Alloc and free never target the same entry: alloc needs an invalid
    // entry, free needs a valid one.
    always_comb begin
        w_rt_valid_nxt = r_rt_valid;
        if (w_hs) begin
            w_rt_valid_nxt[w_id] = 1'b1;
        end
        if (w_free) begin
            w_rt_valid_nxt[mem_resp_id_i] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rt_valid    <= '0;
            for (int i = 0; i < RT_DEPTH; i++) begin
                r_rt_port[i] <= '0;
            end
            r_ptr         <= '0;
            r_lock        <= 1'b0;
            r_lock_sel    <= '0;
            r_lock_id     <= '0;
            r_outstanding <= '0;
            r_rt_err      <= 1'b0;
        end else begin
            r_rt_valid <= w_rt_valid_nxt;
            r_rt_err   <= w_err;
            if (w_hs) begin
                r_rt_port[w_id] <= w_sel;
                r_ptr           <= w_ptr_nxt;
                r_lock          <= 1'b0;
            end else if (w_mem_req_valid) begin
                r_lock     <= 1'b1;
                r_lock_sel <= w_sel;
                r_lock_id  <= w_id;
            end
            case ({w_hs, w_free})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign mem_req_valid_o = w_mem_req_valid;
    assign mem_req_sel_o   = w_sel;
    assign mem_req_id_o    = w_id;
    assign mem_resp_sel_o  = w_resp_hit ? r_rt_port[mem_resp_id_i] : '0;
    assign outstanding_o   = r_outstanding;
    assign rt_err_o        = r_rt_err;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(w_hs && r_rt_valid[w_id]));
            assert (r_outstanding <= (ID_W + 1)'(RT_DEPTH));
            assert ($onehot0(req_ready_o));
        end
    end
`endif

endmodule
`default_nettype wire
